// File: rtl/flp_int_extract_if.sv
// Request/result bundle between the float-to-decimal front stage and its user.
// The master drives the request; the slave (flp_int_extract) returns the result.
interface flp_int_extract_if;
  logic        start;
  logic [31:0] flp_in;
  logic        busy;
  logic        done;
  logic [23:0] Q;
  logic [23:0] frac;
  logic        sign;
  logic        ovf;
  logic        nan;

  modport master (
    output start, flp_in,
    input  busy, done, Q, frac, sign, ovf, nan
  );

  modport slave (
    input  start, flp_in,
    output busy, done, Q, frac, sign, ovf, nan
  );
endinterface

// File: rtl/flp_int_extract.sv
// Unpacks an IEEE-754 single and aligns its significand one bit per clock,
// producing the integer magnitude Q, a truncated 24-bit fraction, sign and flags.
module flp_int_extract #(
  parameter logic [23:0] SAT_VAL = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  flp_int_extract_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [47:0] w;
  logic [4:0]  cnt;
  logic        left;
  logic        sign_r, ovf_r, nan_r;
  logic        busy_q, done_q, sign_q, ovf_q, nan_q;
  logic [23:0] q_q, frac_q;

  logic [7:0]        exp_f;
  logic [22:0]       mant;
  logic signed [8:0] e;
  logic signed [8:0] neg_e;
  logic [47:0]       ld_w;
  logic [4:0]        ld_cnt;
  logic              ld_left, ld_ovf, ld_nan;

  assign exp_f = bus.flp_in[30:23];
  assign mant  = bus.flp_in[22:0];
  assign e     = $signed({1'b0, exp_f}) - 9'sd127;
  assign neg_e = -e;

  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    ld_w    = '0;
    ld_cnt  = '0;
    ld_left = 1'b1;
    ld_ovf  = 1'b0;
    ld_nan  = 1'b0;
    if (exp_f == 8'hFF) begin
      ld_nan = (mant != '0);
      ld_ovf = (mant == '0);
    end else if (exp_f != 8'h00) begin
      if (e >= 9'sd24) begin
        ld_ovf = 1'b1;
      end else if (e >= 9'sd0) begin
        ld_w   = {23'd0, 1'b1, mant, 1'b0};
        ld_cnt = e[4:0];
      end else if (e >= -9'sd24) begin
        ld_w    = {23'd0, 1'b1, mant, 1'b0};
        ld_left = 1'b0;
        ld_cnt  = neg_e[4:0];
      end
      // E <= -25 underflows to zero: the defaults already describe it.
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      w      <= '0;
      cnt    <= '0;
      left   <= 1'b1;
      sign_r <= 1'b0;
      ovf_r  <= 1'b0;
      nan_r  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      q_q    <= '0;
      frac_q <= '0;
      sign_q <= 1'b0;
      ovf_q  <= 1'b0;
      nan_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign_r <= bus.flp_in[31];
            ovf_r  <= ld_ovf;
            nan_r  <= ld_nan;
            w      <= ld_w;
            cnt    <= ld_cnt;
            left   <= ld_left;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            w   <= left ? (w << 1) : (w >> 1);
            cnt <= cnt - 5'd1;
          end else begin
            // Visible results only change here, so they hold across later conversions.
            q_q    <= ovf_r ? SAT_VAL : w[47:24];
            frac_q <= w[23:0];
            sign_q <= sign_r;
            ovf_q  <= ovf_r;
            nan_q  <= nan_r;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Q    = q_q;
  assign bus.frac = frac_q;
  assign bus.sign = sign_q;
  assign bus.ovf  = ovf_q;
  assign bus.nan  = nan_q;

endmodule

// File: tb/tb_flp_int_extract.sv
// Directed checks of flp_int_extract: a vector table of singles with
// hand-computed results and latencies, plus busy-restart and mid-run reset sequences.
module tb_flp_int_extract;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  flp_int_extract_if bus ();

  flp_int_extract #(.SAT_VAL(24'hFFFFFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] flp;
    logic [23:0] q;
    logic [23:0] frac;
    logic        sign;
    logic        ovf;
    logic        nan;
    int          lat;   // edges from the start-sampling edge to the one raising done
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp_v);
    end
  endtask

  // Waits for done after the start edge; returns edges counted (0 = timed out).
  task automatic wait_done(input int limit, output int edges);
    edges = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic issue(input logic [31:0] flp);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.flp_in = flp;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int edges;
    string tag;
    tag = $sformatf("%08h", v.flp);
    issue(v.flp);
    check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
    wait_done(40, edges);
    check({tag, " latency"}, edges, v.lat);
    check({tag, " Q"},    {8'd0, bus.Q},    {8'd0, v.q});
    check({tag, " frac"}, {8'd0, bus.frac}, {8'd0, v.frac});
    check({tag, " flags"}, {29'd0, bus.sign, bus.ovf, bus.nan}, {29'd0, v.sign, v.ovf, v.nan});
    @(posedge clk); #1;
    check({tag, " done pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  initial begin
    int edges;
    int seen;

    //            flp           Q           frac        s     ovf   nan   lat
    vecs.push_back('{32'h40B80000, 24'd5,      24'hC00000, 1'b0, 1'b0, 1'b0, 3});
    vecs.push_back('{32'hC0B80000, 24'd5,      24'hC00000, 1'b1, 1'b0, 1'b0, 3});
    vecs.push_back('{32'hBEC00000, 24'd0,      24'h600000, 1'b1, 1'b0, 1'b0, 3});
    vecs.push_back('{32'h3F000000, 24'd0,      24'h800000, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{32'h33800000, 24'd0,      24'h000001, 1'b0, 1'b0, 1'b0, 25});
    vecs.push_back('{32'h4B7FFFFF, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0, 1'b0, 24});
    vecs.push_back('{32'h4B800000, 24'hFFFFFF, 24'h000000, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{32'h7FC00000, 24'd0,      24'h000000, 1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{32'hFF800000, 24'hFFFFFF, 24'h000000, 1'b1, 1'b1, 1'b0, 1});
    vecs.push_back('{32'h3F800000, 24'd1,      24'h000000, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{32'h00000001, 24'd0,      24'h000000, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{32'h33000000, 24'd0,      24'h000000, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{32'h41200000, 24'd10,     24'h000000, 1'b0, 1'b0, 1'b0, 4});

    bus.start  = 1'b0;
    bus.flp_in = '0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {bus.busy, bus.done, bus.sign, bus.ovf, bus.nan, 3'd0, bus.Q},
          32'd0);
    check("reset frac", {8'd0, bus.frac}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Start during a long conversion is ignored; previous outputs hold meanwhile.
    issue(32'h4B7FFFFF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.flp_in = 32'h3F800000;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    check("hold Q while busy", {8'd0, bus.Q}, 32'd10);
    wait_done(40, edges);
    check("ignored start latency", edges, 19);
    check("ignored start Q", {8'd0, bus.Q}, 32'hFFFFFF);
    @(posedge clk); #1;
    run_vec('{32'h4B800000, 24'hFFFFFF, 24'h0, 1'b0, 1'b1, 1'b0, 1});
    run_vec('{32'h3F800000, 24'd1, 24'h0, 1'b0, 1'b0, 1'b0, 1});

    // Reset in the middle of a 23-shift conversion aborts it without a done.
    issue(32'h4B7FFFFF);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort outputs", {bus.busy, bus.done, bus.sign, bus.ovf, bus.nan, 3'd0, bus.Q},
          32'd0);
    check("abort frac", {8'd0, bus.frac}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen++;
    end
    check("no done after abort", seen, 0);
    run_vec('{32'h41200000, 24'd10, 24'h0, 1'b0, 1'b0, 1'b0, 4});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

endmodule
